// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: 2-FF sync + deglitch filter, 11-bit frame decode, show-ahead byte FIFO.
// Ports: clk_sys/reset (async, active-high), ps2_clk/ps2_data (async lines), rx_rd/rx_data/rx_valid (FIFO pop side),
//        parity_err/frame_err/overflow (1-cycle pulses). Byte is pushed the cycle after the stop-bit falling edge.
module ps2_rx #(
    parameter int FIFO_BITS = 2,
    parameter int FILT      = 8,
    parameter int TIMEOUT   = 20000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int FW    = $clog2(FILT + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------
    // Input path: index 0 = ps2_clk, index 1 = ps2_data
    // ------------------------------------------------------------------
    logic [1:0]    sync1_q, sync2_q, filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic          clk_dly_q;
    logic          fe;
    logic          dat;

    // A line's filtered value flips only on the FILT-th consecutive
    // synchronized sample that disagrees with it; any agreeing sample
    // restarts the run.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILT - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            clk_dly_q <= 1'b1;
        end else begin
            sync1_q   <= {ps2_data, ps2_clk};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            clk_dly_q <= filt_q[0];
        end
    end

    assign fe  = clk_dly_q & ~filt_q[0];
    assign dat = filt_q[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          abort;

    // Timeout only fires in a cycle without a falling edge, so it never
    // competes with a stop-bit decision.
    assign abort = (state_q != S_IDLE) && !fe && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tmo_d     = (state_q == S_IDLE || fe) ? '0 : tmo_q + TW'(1);

        if (abort) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end else if (fe) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d = {dat, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_d   = dat;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        push_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            push_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            push_q    <= push_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    // ------------------------------------------------------------------
    // Show-ahead FIFO. shift_q still holds the finished byte during the
    // push cycle: a new frame only touches it on its first data bit.
    // ------------------------------------------------------------------
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_BITS:0]   cnt_q, cnt_d;
    logic                 full, pop, wr_en;
    logic                 ovf_q;

    assign full     = (cnt_q == (FIFO_BITS + 1)'(DEPTH));
    assign rx_valid = (cnt_q != '0);
    assign pop      = rx_rd & rx_valid;
    // When full, a same-cycle pop frees the head slot, which is exactly
    // the slot wr_ptr points at, so the write is safe.
    assign wr_en    = push_q & (~full | pop);

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + (FIFO_BITS + 1)'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - (FIFO_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + FIFO_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_BITS'(1);
            end
            cnt_q <= cnt_d;
            ovf_q <= push_q & full & ~pop;
        end
    end

    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow = ovf_q;

endmodule
